updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
- Parametrised successor to the fixed 4-bit free-running down counter.
- Synchronous up/down counter with runtime direction, enable, parallel load, programmable modulus, and wrap or saturate mode.
- Registered terminal-count pulse for cascading and for timer/sequencer use elsewhere in the lab designs.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- RST_VAL, {WIDTH{1'b1}}, value of q after reset (default all ones, i.e. 4'hF).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- mod_max  input  WIDTH  upper bound of count range; range is 0..mod_max inclusive.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- at_bound  output  1  combinational: (up && q==mod_max) || (!up && q==0).

Behaviour:
- Priority per rising edge: rst > load > en > hold.
- Reset: rst high at a rising edge gives q=RST_VAL and tc=0 on the following cycle. RST_VAL is not clamped to mod_max. Reset asserted mid-count or mid-load overrides everything.
- Load: q <= min(load_val, mod_max), tc <= 0. Load wins over en in the same cycle, and no step occurs that cycle.
- en=0, no load: q holds, tc <= 0.
- en=1, q <= mod_max:
  - up, q<mod_max: q <= q+1, tc <= 0.
  - up, q==mod_max: wrap mode gives q <= 0; saturate mode gives q holds at mod_max. tc <= 1 in both modes.
  - down, q>0: q <= q-1, tc <= 0.
  - down, q==0: wrap mode gives q <= mod_max; saturate mode gives q holds at 0. tc <= 1 in both modes.
- en=1, q > mod_max (mod_max lowered at runtime, or RST_VAL > mod_max): q <= mod_max in both directions and modes, tc <= 0.
- tc timing:
  - Asserted for exactly the one cycle following a boundary step.
  - In saturate mode with en held at a boundary, tc stays high each cycle (one pulse per attempted step).
- mod_max==0: q stays 0 and every enabled step asserts tc.
- Direction or mode change takes effect on the same edge it is sampled; there is no pipeline.
- Arithmetic is modulo 2^WIDTH internally. Any boundary comparison uses unsigned WIDTH-bit compare, with no carry out beyond WIDTH.
- Latency: q and tc reflect inputs sampled at edge N starting from edge N.

Test Plan:
- Reset/free-run down, WIDTH=4, mod_max=15, up=0, wrap, en=1, rst high for one edge:
  - q=F after reset, then E, D, ..., 0, F.
  - tc high exactly in the cycle where q=F after 0.
- Up wrap with modulus, mod_max=9, up=1, load 7:
  - q = 7, 8, 9, 0, 1.
  - tc high only in the cycle showing 0.
- Saturate both ends, sat_mode=1, mod_max=5:
  - Counting up: q=5 held, tc high every enabled cycle at the bound.
  - Switch up=0: q = 4, 3, 2, 1, 0, 0, with tc high from the second 0 onward.
- Load priority and clamp, mod_max=9:
  - load=1, en=1, load_val=C gives q=9 with no step that cycle.
  - load_val=3 with en=1 gives q=3, not 4.
- Runtime mod_max reduction, q=E, mod_max changed 15→6, en=1:
  - Next q=6 with tc=0, then 0 (up, wrap) with tc=1.
- Mid-operation reset and enable gating:
  - en=0 holds q=4 for 3 cycles with tc=0.
  - rst asserted with load=1 and en=1 gives q=F and tc=0. The load is ignored.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Up/down counter with enable, parallel load, programmable modulus and wrap/saturate mode.
// Latency: q and tc are registered and update on the edge where the inputs are sampled; at_bound is combinational.
// Backpressure: none; en gates counting and the counter holds while en is low.
module updown_counter_mod #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_bound
);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  logic             w_over;
  logic             w_at_top;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_tc;

  assign w_over         = (r_q > mod_max);
  assign w_at_top       = (r_q == mod_max);
  assign w_at_zero      = (r_q == '0);
  assign w_load_clamped = (load_val > mod_max) ? mod_max : load_val;

  // Next value and terminal-count flag for one enabled step.
  always_comb begin
    w_step_q  = r_q;
    w_step_tc = 1'b0;
    if (w_over) begin
      // Count left outside the range (mod_max lowered, or reset value above it): pull back in silently.
      w_step_q  = mod_max;
      w_step_tc = 1'b0;
    end else if (up) begin
      if (w_at_top) begin
        w_step_q  = sat_mode ? r_q : '0;
        w_step_tc = 1'b1;
      end else begin
        w_step_q  = r_q + 1'b1;
      end
    end else begin
      if (w_at_zero) begin
        w_step_q  = sat_mode ? r_q : mod_max;
        w_step_tc = 1'b1;
      end else begin
        w_step_q  = r_q - 1'b1;
      end
    end
  end

  // Count register with priority reset > load > enable > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= RST_VAL;
      r_tc <= 1'b0;
    end else if (load) begin
      r_q  <= w_load_clamped;
      r_tc <= 1'b0;
    end else if (en) begin
      r_q  <= w_step_q;
      r_tc <= w_step_tc;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign q        = r_q;
  assign tc       = r_tc;
  assign at_bound = (up && w_at_top) || (!up && w_at_zero);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod: directed scenarios then randomized traffic.
// Expected values come from an integer-arithmetic reference model of the counting rules.
// Inputs are driven just after the rising edge; outputs are sampled 1 time unit after it.
module tb_updown_counter_mod;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         sat_mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] mod_max = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         at_bound;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_q     = 0;
  int m_tc    = 0;
  bit m_valid = 1'b0;

  updown_counter_mod #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .sat_mode (sat_mode),
    .load     (load),
    .load_val (load_val),
    .mod_max  (mod_max),
    .q        (q),
    .tc       (tc),
    .at_bound (at_bound)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check at_bound before the edge, advance the model, check q/tc after it.
  task automatic cyc(input bit r, input bit l, input bit e, input bit u, input bit s,
                     input int lv, input int mm);
    int nq;
    int ntc;
    rst      = r;
    load     = l;
    en       = e;
    up       = u;
    sat_mode = s;
    load_val = lv[W-1:0];
    mod_max  = mm[W-1:0];
    #1;
    if (m_valid)
      chk("at_bound", {31'd0, at_bound}, ((u && m_q == mm) || (!u && m_q == 0)) ? 32'd1 : 32'd0);
    @(posedge clk);
    nq  = m_q;
    ntc = 0;
    if (r) begin
      nq = (1 << W) - 1;
    end else if (l) begin
      nq = (lv < mm) ? lv : mm;
    end else if (e) begin
      if (m_q > mm)            nq = mm;
      else if (u && m_q == mm) begin nq = s ? mm : 0; ntc = 1; end
      else if (u)              nq = m_q + 1;
      else if (m_q == 0)       begin nq = s ? 0 : mm; ntc = 1; end
      else                     nq = m_q - 1;
    end
    if (r || m_valid) begin
      m_q     = nq;
      m_tc    = ntc;
      m_valid = 1'b1;
    end
    #1;
    if (m_valid) begin
      chk("q", {28'd0, q}, m_q);
      chk("tc", {31'd0, tc}, m_tc);
    end
  endtask

  initial begin
    // Reset, then free-running down count with wrap over the full range.
    cyc(1, 0, 1, 0, 0, 0, 15);
    chk("rst_q_F", {28'd0, q}, 32'd15);
    chk("rst_tc_0", {31'd0, tc}, 32'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0, 0, 15);
    chk("down_wrap_q_F", {28'd0, q}, 32'd15);
    chk("down_wrap_tc", {31'd0, tc}, 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 15);
    chk("after_wrap_q_E", {28'd0, q}, 32'd14);

    // Up count, modulus 10, starting from a load of 7.
    cyc(0, 1, 0, 1, 0, 7, 9);
    chk("load7", {28'd0, q}, 32'd7);
    cyc(0, 0, 1, 1, 0, 0, 9);
    cyc(0, 0, 1, 1, 0, 0, 9);
    chk("up_9_tc0", {31'd0, tc}, 32'd0);
    cyc(0, 0, 1, 1, 0, 0, 9);
    chk("up_wrap_0", {28'd0, q}, 32'd0);
    chk("up_wrap_tc", {31'd0, tc}, 32'd1);
    cyc(0, 0, 1, 1, 0, 0, 9);
    chk("up_1_tc0", {31'd0, tc}, 32'd0);

    // Saturation at both ends, mod_max = 5.
    cyc(0, 1, 0, 1, 1, 3, 5);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1, 0, 5);
    chk("sat_top_q", {28'd0, q}, 32'd5);
    chk("sat_top_tc", {31'd0, tc}, 32'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1, 0, 5);
    chk("sat_first0_tc", {31'd0, tc}, 32'd0);
    cyc(0, 0, 1, 0, 1, 0, 5);
    chk("sat_bot_q", {28'd0, q}, 32'd0);
    chk("sat_bot_tc", {31'd0, tc}, 32'd1);

    // Load beats enable, and is clamped to mod_max.
    cyc(0, 1, 1, 1, 0, 12, 9);
    chk("load_clamp", {28'd0, q}, 32'd9);
    cyc(0, 1, 1, 1, 0, 3, 9);
    chk("load_no_step", {28'd0, q}, 32'd3);

    // Lowering mod_max below the count.
    cyc(0, 1, 0, 1, 0, 14, 15);
    cyc(0, 0, 1, 1, 0, 0, 6);
    chk("shrink_q6", {28'd0, q}, 32'd6);
    chk("shrink_tc0", {31'd0, tc}, 32'd0);
    cyc(0, 0, 1, 1, 0, 0, 6);
    chk("shrink_wrap0", {28'd0, q}, 32'd0);

    // Enable gating, then reset overriding load and enable.
    cyc(0, 1, 0, 1, 0, 4, 9);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 9);
    chk("hold_q4", {28'd0, q}, 32'd4);
    cyc(1, 1, 1, 1, 0, 2, 9);
    chk("rst_over_load", {28'd0, q}, 32'd15);
    chk("rst_over_tc", {31'd0, tc}, 32'd0);

    // Zero modulus: stays 0, every step is terminal.
    cyc(0, 1, 0, 0, 0, 5, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("mod0_tc", {31'd0, tc}, 32'd1);

    // Randomized traffic against the model.
    begin
      int mm;
      mm = 15;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 9) == 0) mm = $urandom_range(0, 15);
        cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15), mm);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
